conv_seq_ctrl: RTL and testbench



---
 rtl/conv_seq_ctrl_if.sv | 32 +++
 rtl/conv_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_ctrl_if.sv
// Handshake and memory-address bundle between conv_seq_ctrl and its neighbours.
// The master modport is the sequencer side; the slave modport is its environment.
interface conv_seq_ctrl_if #(
  parameter int T = 8,
  parameter int N = 128,
  parameter int M = 32
);
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (M > 1) ? $clog2(M) : 1;

  logic                 start;
  logic signed [T-1:0]  acc_data;
  logic                 m_ready_y;
  logic [XW-1:0]        xmem_addr;
  logic [FW-1:0]        fmem_addr;
  logic                 mac_en;
  logic                 mac_first;
  logic                 m_valid_y;
  logic signed [T-1:0]  m_data_out_y;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, acc_data, m_ready_y,
    output xmem_addr, fmem_addr, mac_en, mac_first, m_valid_y, m_data_out_y, busy, done
  );

  modport slave (
    output start, acc_data, m_ready_y,
    input  xmem_addr, fmem_addr, mac_en, mac_first, m_valid_y, m_data_out_y, busy, done
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Address/MAC sequencer for a single-MAC 1-D convolution with a one-entry output register.
// Define CONV_SEQ_RELU_EN to clamp negative sums to zero on capture.
module conv_seq_ctrl #(
  parameter int T      = 8,
  parameter int N      = 128,
  parameter int M      = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  conv_seq_ctrl_if.master bus
);
  localparam int P  = N - M + 1;
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (P > 1) ? $clog2(P) : 1;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [FW-1:0] K_LAST = FW'(M - 1);
  localparam logic [JW-1:0] J_LAST = JW'(P - 1);
  localparam logic [DW-1:0] D_LAST = DW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [JW-1:0]       j;
  logic [FW-1:0]       k;
  logic [DW-1:0]       dcnt;
  logic [XW-1:0]       xaddr;
  logic [FW-1:0]       faddr;
  logic [RD_LAT-1:0]   vld_pipe;
  logic [RD_LAT-1:0]   first_pipe;
  logic                y_vld;
  logic signed [T-1:0] y_data;
  logic                cap, issue, issue_first, busy_c, done_c;

  function automatic logic signed [T-1:0] capture_val(input logic signed [T-1:0] a);
`ifdef CONV_SEQ_RELU_EN
    return a[T-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cap         = 1'b0;
    issue       = 1'b0;
    issue_first = 1'b0;
    busy_c      = 1'b1;
    done_c      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        issue       = 1'b1;
        issue_first = (k == '0);
        if (k == K_LAST) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (dcnt == D_LAST) state_nx = S_WRITE;
      end
      S_WRITE: begin
        // A stalled WRITE simply waits; the MAC is idle so the sum is held.
        cap = !y_vld || bus.m_ready_y;
        if (cap) state_nx = (j == J_LAST) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done_c   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters and registered address pair (xmem = j+k, fmem = k)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      j     <= '0;
      k     <= '0;
      dcnt  <= '0;
      xaddr <= '0;
      faddr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            j     <= '0;
            k     <= '0;
            xaddr <= '0;
            faddr <= '0;
          end
        end
        S_ISSUE: begin
          dcnt <= '0;
          if (k != K_LAST) begin
            k     <= k + FW'(1);
            xaddr <= xaddr + XW'(1);
            faddr <= faddr + FW'(1);
          end
        end
        S_DRAIN: dcnt <= dcnt + DW'(1);
        S_WRITE: begin
          if (cap && (j != J_LAST)) begin
            j     <= j + JW'(1);
            k     <= '0;
            xaddr <= XW'(j) + XW'(1);
            faddr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-latency alignment of issue-valid and first-term flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
    end else begin
      vld_pipe[0]   <= issue;
      first_pipe[0] <= issue_first;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
      end
    end
  end

  // One-entry output register; a simultaneous pop and push keeps it full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_vld  <= 1'b0;
      y_data <= '0;
    end else if (cap) begin
      y_vld  <= 1'b1;
      y_data <= capture_val(bus.acc_data);
    end else if (y_vld && bus.m_ready_y) begin
      y_vld  <= 1'b0;
    end
  end

  assign bus.xmem_addr    = xaddr;
  assign bus.fmem_addr    = faddr;
  assign bus.mac_en       = vld_pipe[RD_LAT-1];
  assign bus.mac_first    = first_pipe[RD_LAT-1];
  assign bus.m_valid_y    = y_vld;
  assign bus.m_data_out_y = y_data;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: vector table, corner sequences and a random run
// against an interval-based reference model.
module tb_conv_seq_ctrl;
  localparam int T = 8, N = 128, M = 32, RDL = 1, P = N - M + 1;
  localparam int NS = 8, MS = 8, RDLS = 2;
  localparam int SX = 0, SF = 1, SEN = 2, SFI = 3, SV = 4, SD = 5, SB = 6, SDN = 7;
`ifdef CONV_SEQ_RELU_EN
  localparam logic [7:0] NEG5_OUT = 8'h00;
`else
  localparam logic [7:0] NEG5_OUT = 8'hFB;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] acc;
    int         sig;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0, bad = 0, cyc = 0, pops = 0, base = 0;
  vec_t tbl[$];
  string sig_name [8];

  // reference model state
  bit         running, finished, st, rdy, in_issue, cap, yv;
  logic [7:0] yd, acc;
  int         p, is, done_cyc, hold;

  conv_seq_ctrl_if #(.T(T), .N(N),  .M(M))  bus ();
  conv_seq_ctrl_if #(.T(T), .N(NS), .M(MS)) bus_s ();

  conv_seq_ctrl #(.T(T), .N(N), .M(M), .RD_LAT(RDL)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  conv_seq_ctrl #(.T(T), .N(NS), .M(MS), .RD_LAT(RDLS)) dut_s (
    .clk(clk), .reset(rst), .bus(bus_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.m_valid_y && bus.m_ready_y) pops <= pops + 1;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      SX:  return 32'(bus.xmem_addr);
      SF:  return 32'(bus.fmem_addr);
      SEN: return 32'(bus.mac_en);
      SFI: return 32'(bus.mac_first);
      SV:  return 32'(bus.m_valid_y);
      SD:  return {24'b0, bus.m_data_out_y};
      SB:  return 32'(bus.busy);
      default: return 32'(bus.done);
    endcase
  endfunction

  function automatic logic [7:0] ref_out(input logic [7:0] a);
`ifdef CONV_SEQ_RELU_EN
    return a[7] ? 8'h00 : a;
`else
    return a;
`endif
  endfunction

  task automatic add(input int c, input logic [7:0] a, input int s, input int e);
    tbl.push_back(vec_t'{c, a, s, 32'(e)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;   bus.m_ready_y = 1'b1;   bus.acc_data = '0;
    bus_s.start = 1'b0; bus_s.m_ready_y = 1'b1; bus_s.acc_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    cyc = 0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 8; s++) check({tag, " ", sig_name[s]}, sig_val(s), 32'd0);
  endtask

  initial begin
    sig_name = '{"xmem", "fmem", "mac_en", "mac_first", "valid", "data", "busy", "done"};

    // ---- reset values
    rst = 1'b1;
    bus.start = 1'b0;   bus.m_ready_y = 1'b1;   bus.acc_data = '0;
    bus_s.start = 1'b0; bus_s.m_ready_y = 1'b1; bus_s.acc_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    check("rst small busy", 32'(bus_s.busy), 32'd0);
    check("rst small valid", 32'(bus_s.m_valid_y), 32'd0);

    // ---- table-driven default run, ready held high
    add(1, 8'h00, SX, 0);  add(1, 8'h00, SF, 0);  add(1, 8'h00, SB, 1);
    add(1, 8'h00, SEN, 0); add(1, 8'h00, SFI, 0); add(1, 8'h00, SV, 0); add(1, 8'h00, SDN, 0);
    add(2, 8'h00, SEN, 1); add(2, 8'h00, SFI, 1); add(2, 8'h00, SX, 1); add(2, 8'h00, SF, 1);
    add(3, 8'h00, SFI, 0); add(3, 8'h00, SEN, 1);
    add(32, 8'h00, SX, 31); add(32, 8'h00, SF, 31);
    add(33, 8'h00, SEN, 1); add(33, 8'h00, SB, 1);
    add(34, 8'hFB, SEN, 0); add(34, 8'hFB, SV, 0);
    add(35, 8'h00, SV, 1);  add(35, 8'h00, SD, int'(NEG5_OUT));
    add(35, 8'h00, SX, 1);  add(35, 8'h00, SF, 0); add(35, 8'h00, SFI, 0);
    add(36, 8'h00, SV, 0);  add(36, 8'h00, SFI, 1); add(36, 8'h00, SX, 2); add(36, 8'h00, SF, 1);
    add(66, 8'h00, SX, 32); add(66, 8'h00, SF, 31);
    add(68, 8'h45, SEN, 0); add(68, 8'h45, SV, 0);
    add(69, 8'h00, SV, 1);  add(69, 8'h00, SD, 8'h45);
    add(3296, 8'h00, SX, 127); add(3296, 8'h00, SF, 31);
    add(3298, 8'h00, SDN, 0);  add(3298, 8'h00, SB, 1);
    add(3299, 8'h00, SDN, 1);  add(3299, 8'h00, SB, 1); add(3299, 8'h00, SV, 1);
    add(3300, 8'h00, SDN, 0);  add(3300, 8'h00, SB, 0); add(3300, 8'h00, SV, 0);

    do_reset();
    base = pops;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) step();
      bus.acc_data = tbl[i].acc;
      check($sformatf("tbl c%0d %s", tbl[i].cyc, sig_name[tbl[i].sig]), sig_val(tbl[i].sig), tbl[i].exp);
    end
    check("tbl output count", 32'(pops - base), 32'(P));

    // ---- 20-cycle stall at the second output
    do_reset();
    base = pops;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (cyc < 34) step();
    bus.acc_data = 8'h12;
    step();
    bus.m_ready_y = 1'b0;
    bus.acc_data = 8'h77;
    while (cyc < 88) begin
      check($sformatf("stall c%0d valid", cyc), 32'(bus.m_valid_y), 32'd1);
      check($sformatf("stall c%0d data", cyc), {24'b0, bus.m_data_out_y}, 32'h12);
      if (cyc >= 68) begin
        check($sformatf("stall c%0d mac_en", cyc), 32'(bus.mac_en), 32'd0);
        check($sformatf("stall c%0d busy", cyc), 32'(bus.busy), 32'd1);
      end
      step();
    end
    check("stall c88 data", {24'b0, bus.m_data_out_y}, 32'h12);
    bus.m_ready_y = 1'b1;
    bus.acc_data = 8'h34;
    step();
    check("stall c89 valid", 32'(bus.m_valid_y), 32'd1);
    check("stall c89 data", {24'b0, bus.m_data_out_y}, 32'h34);
    bus.acc_data = 8'h00;
    step();
    check("stall c90 valid", 32'(bus.m_valid_y), 32'd0);
    for (int n = 0; n < 4000 && !bus.done; n++) step();
    check("stall done", 32'(bus.done), 32'd1);
    check("stall done cycle", 32'(cyc), 32'd3319);
    step();
    check("stall output count", 32'(pops - base), 32'(P));

    // ---- N=M=8, RD_LAT=2
    do_reset();
    bus_s.start = 1'b1;
    step();
    bus_s.start = 1'b0;
    while (cyc <= 13) begin
      bus_s.acc_data = (cyc == 11) ? 8'h5A : 8'hA5;
      check($sformatf("small c%0d mac_en", cyc), 32'(bus_s.mac_en), 32'(cyc >= 3 && cyc <= 10));
      check($sformatf("small c%0d mac_first", cyc), 32'(bus_s.mac_first), 32'(cyc == 3));
      check($sformatf("small c%0d valid", cyc), 32'(bus_s.m_valid_y), 32'(cyc == 12));
      check($sformatf("small c%0d done", cyc), 32'(bus_s.done), 32'(cyc == 12));
      check($sformatf("small c%0d busy", cyc), 32'(bus_s.busy), 32'(cyc <= 12));
      if (cyc <= 8) begin
        check($sformatf("small c%0d xmem", cyc), 32'(bus_s.xmem_addr), 32'(cyc - 1));
        check($sformatf("small c%0d fmem", cyc), 32'(bus_s.fmem_addr), 32'(cyc - 1));
      end
      if (cyc == 12) check("small data", {24'b0, bus_s.m_data_out_y}, 32'h5A);
      step();
    end

    // ---- asynchronous reset in cycle 17 of ISSUE, then clean restart
    do_reset();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (cyc < 17) step();
    check("pre-rst xmem", 32'(bus.xmem_addr), 32'd16);
    check("pre-rst mac_en", 32'(bus.mac_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async rst");
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    cyc = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart c1 xmem", 32'(bus.xmem_addr), 32'd0);
    check("restart c1 fmem", 32'(bus.fmem_addr), 32'd0);
    check("restart c1 busy", 32'(bus.busy), 32'd1);
    step();
    check("restart c2 mac_first", 32'(bus.mac_first), 32'd1);
    while (cyc < 17) step();
    check("restart c17 xmem", 32'(bus.xmem_addr), 32'd16);

    // ---- random backpressure, data and stray start pulses vs reference model
    do_reset();
    running = 0; finished = 0; yv = 0; yd = '0; p = 0; is = 0; done_cyc = -1; hold = 0;
    for (int n = 0; n < 12000 && !finished; n++) begin
      st  = (cyc == 0) || ($urandom_range(0, 15) == 0);
      if (hold > 0) begin
        rdy = 1'b0;
        hold--;
      end else begin
        rdy = 1'b1;
        if ($urandom_range(0, 29) == 0) hold = $urandom_range(1, 60);
      end
      acc = 8'($urandom);
      bus.start = st; bus.m_ready_y = rdy; bus.acc_data = acc;

      in_issue = running && done_cyc < 0 && cyc >= is && cyc < is + M;
      if (in_issue) begin
        check($sformatf("rnd c%0d xmem", cyc), 32'(bus.xmem_addr), 32'(p + cyc - is));
        check($sformatf("rnd c%0d fmem", cyc), 32'(bus.fmem_addr), 32'(cyc - is));
      end
      check($sformatf("rnd c%0d mac_en", cyc), 32'(bus.mac_en),
            32'(running && cyc >= is + RDL && cyc < is + RDL + M));
      check($sformatf("rnd c%0d mac_first", cyc), 32'(bus.mac_first), 32'(running && cyc == is + RDL));
      check($sformatf("rnd c%0d valid", cyc), 32'(bus.m_valid_y), 32'(yv));
      if (yv) check($sformatf("rnd c%0d data", cyc), {24'b0, bus.m_data_out_y}, {24'b0, yd});
      check($sformatf("rnd c%0d busy", cyc), 32'(bus.busy), 32'(running));
      check($sformatf("rnd c%0d done", cyc), 32'(bus.done), 32'(cyc == done_cyc));

      cap = running && done_cyc < 0 && cyc >= is + M + RDL && (!yv || rdy);
      if (!running && st) begin
        running = 1; is = cyc + 1; p = 0;
      end
      if (cap) begin
        yv = 1; yd = ref_out(acc);
        if (p == P - 1) done_cyc = cyc + 1;
        else begin
          p++;
          is = cyc + 1;
        end
      end else if (yv && rdy) yv = 0;
      if (running && cyc == done_cyc) begin
        running = 0; finished = 1;
      end
      step();
    end
    check("rnd run finished", 32'(finished), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
